fetch_ctrl: RTL and testbench

Sequencing controller for the fetch stage. Drives the PC mux select and PC enable of the fetch datapath: boots from the fixed initial instruction address, advances PC by 2 per accepted instruction, and redirects to a branch target. It also holds on decode backpressure, stops on a halt request, and flags which instruction words on the memory output are valid for decode.

---
 rtl/fetch_ctrl.sv | 98 +++++++++
 tb/tb_fetch_ctrl.sv | 122 ++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage PC sequencing FSM; FETCH_CTRL_PERF_EN adds fetch/stall counters.
module fetch_ctrl #(
  parameter logic [15:0] RESET_TARGET = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_req,
  input  logic [15:0] branch_target,
  input  logic        halt_req,
  output logic [1:0]  sel_pc,
  output logic        enable_pc,
  output logic [15:0] branch_pc,
  output logic        inst_valid,
  output logic [2:0]  state,
  output logic [15:0] fetch_count,
  output logic [15:0] stall_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, BOOT = 3'd1, RUN = 3'd2, REDIRECT = 3'd3, HALT = 3'd4} state_e;
  state_e      state_q, state_d;
  logic [15:0] branch_pc_q, branch_pc_d;
  always_comb begin
    state_d     = state_q;
    branch_pc_d = branch_pc_q;
    sel_pc      = 2'b01;
    enable_pc   = 1'b0;
    inst_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        sel_pc  = 2'b00;
        state_d = start ? BOOT : IDLE;
      end
      BOOT: begin
        sel_pc    = 2'b00;
        enable_pc = 1'b1;
        state_d   = RUN;
      end
      RUN: begin
        inst_valid = 1'b1;
        if (halt_req) state_d = HALT;
        else if (branch_req) begin
          branch_pc_d = branch_target;
          state_d     = REDIRECT;
        end else enable_pc = !stall;
      end
      REDIRECT: begin
        if (halt_req) state_d = HALT;
        else if (branch_req) branch_pc_d = branch_target;
        else begin
          sel_pc    = 2'b10;
          enable_pc = 1'b1;
          state_d   = RUN;
        end
      end
      HALT: state_d = start ? BOOT : HALT;
      default: begin
        sel_pc  = 2'b00;
        state_d = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      branch_pc_q <= RESET_TARGET;
    end else begin
      state_q     <= state_d;
      branch_pc_q <= branch_pc_d;
    end
  end
  assign state     = state_q;
  assign branch_pc = branch_pc_q;
`ifdef FETCH_CTRL_PERF_EN
  logic        accept, stall_cyc;
  logic [15:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;
  assign accept    = state_q == RUN && !stall && !halt_req && !branch_req;
  assign stall_cyc = state_q == RUN && stall && !halt_req && !branch_req;
  always_comb begin
    fetch_count_d = (accept && !(&fetch_count_q)) ? fetch_count_q + 16'd1 : fetch_count_q;
    stall_count_d = (stall_cyc && !(&stall_count_q)) ? stall_count_q + 16'd1 : stall_count_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = 16'h0000;
  assign stall_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench; a small PC datapath driven by the DUT is checked against the model's expected fetch address.
module tb_fetch_ctrl;
  localparam logic [15:0] RT   = 16'h1234;
  localparam logic [15:0] INIT = 16'h0100;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, stall = 1'b0, branch_req = 1'b0, halt_req = 1'b0;
  logic [15:0] branch_target = '0;
  logic [1:0]  sel_pc;
  logic        enable_pc, inst_valid;
  logic [15:0] branch_pc, fetch_count, stall_count;
  logic [2:0]  state;
  logic [15:0] pc = '0;
  always #5 clk = ~clk;
  fetch_ctrl #(.RESET_TARGET(RT)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .branch_req(branch_req),
    .branch_target(branch_target), .halt_req(halt_req), .sel_pc(sel_pc), .enable_pc(enable_pc),
    .branch_pc(branch_pc), .inst_valid(inst_valid), .state(state),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );
  always @(posedge clk)
    if (enable_pc) pc <= sel_pc == 2'b00 ? INIT : sel_pc == 2'b01 ? pc + 16'd2 : sel_pc == 2'b10 ? branch_pc : 16'h0000;
  typedef struct {
    int st; int sel; int en; int v; int bp; int fc; int sc; int pc;
  } exp_t;
  exp_t q[$];
  int compared = 0, mismatched = 0;
  localparam int S_IDLE = 0, S_BOOT = 1, S_RUN = 2, S_RED = 3, S_HALT = 4;
  int ms, mfc, msc;
  logic [15:0] mbp, mpc;
  task automatic chk(input string n, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, req, $time);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", int'(state), e.st);
      chk("sel_pc", int'(sel_pc), e.sel);
      chk("enable_pc", int'(enable_pc), e.en);
      chk("inst_valid", int'(inst_valid), e.v);
      chk("branch_pc", int'(branch_pc), e.bp);
      chk("fetch_count", int'(fetch_count), e.fc);
      chk("stall_count", int'(stall_count), e.sc);
      if (e.v == 1) chk("fetch_pc", int'(pc), e.pc);
    end
  end
  task automatic cyc(input bit st, input bit sl, input bit br, input bit hl, input bit rs, input logic [15:0] tg);
    exp_t e;
    int nxt;
    bit acc, stl;
    logic [15:0] nbp;
    start = st; stall = sl; branch_req = br; halt_req = hl; reset = rs; branch_target = tg;
    e.sel = 1; e.en = 0; e.v = 0; nxt = ms; nbp = mbp; acc = 0; stl = 0;
    if (ms == S_IDLE) begin
      e.sel = 0;
      if (st) nxt = S_BOOT;
    end else if (ms == S_BOOT) begin
      e.sel = 0; e.en = 1; nxt = S_RUN;
    end else if (ms == S_RUN) begin
      e.v = 1;
      if (hl) nxt = S_HALT;
      else if (br) begin nbp = tg; nxt = S_RED; end
      else if (sl) stl = 1;
      else begin e.sel = 1; e.en = 1; acc = 1; end
    end else if (ms == S_RED) begin
      if (hl) nxt = S_HALT;
      else if (br) nbp = tg;
      else begin e.sel = 2; e.en = 1; nxt = S_RUN; end
    end else if (st) nxt = S_BOOT;
    e.st = ms; e.bp = int'(mbp); e.pc = int'(mpc);
`ifdef FETCH_CTRL_PERF_EN
    e.fc = mfc; e.sc = msc;
`else
    e.fc = 0; e.sc = 0;
`endif
    q.push_back(e);
    if (ms == S_BOOT) mpc = INIT;
    if (acc) mpc = mpc + 16'd2;
    if (ms == S_RED && e.en == 1) mpc = mbp;
    if (acc && mfc < 65535) mfc++;
    if (stl && msc < 65535) msc++;
    ms = nxt; mbp = nbp;
    if (rs) begin ms = S_IDLE; mbp = RT; mfc = 0; msc = 0; end
    @(posedge clk); #1;
  endtask
  initial begin
    int guard;
    repeat (2) @(posedge clk);
    #1;
    ms = S_IDLE; mbp = RT; mfc = 0; msc = 0; mpc = '0;
    cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 0, 16'h0);
    repeat (3) cyc(0, 0, 0, 0, 0, 16'h0);
    repeat (3) cyc(1, 1, 0, 0, 0, 16'h0);
    cyc(0, 0, 1, 0, 0, 16'h0040);
    repeat (2) cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(0, 1, 1, 0, 0, 16'h0020);
    cyc(0, 1, 1, 0, 0, 16'h0080);
    repeat (2) cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(0, 0, 1, 1, 0, 16'h0500);
    repeat (2) cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(1, 0, 0, 0, 0, 16'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 16'h0);
    cyc(0, 0, 1, 0, 0, 16'h0300);
    cyc(0, 0, 0, 0, 1, 16'h0);
    repeat (2) cyc(0, 0, 0, 0, 0, 16'h0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
          $urandom_range(0, 24) == 0, $urandom_range(0, 199) == 0, 16'($urandom) & 16'hFFFE);
    guard = 0;
    while (q.size() > 0 && guard < 10) begin @(posedge clk); guard++; end
    if (q.size() > 0) begin
      compared++; mismatched++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
